// File: rtl/ex_pkg.sv
// rtl/ex_pkg.sv - shared types and opcode constants for the EX/MEM stage
package ex_pkg;

  localparam int EX_DATA_W = 32;
  localparam int EX_REG_AW = 5;

  localparam logic [3:0] ALUC_ADD = 4'b0010;
  localparam logic [3:0] ALUC_SUB = 4'b0011;

  typedef struct packed {
    logic [EX_DATA_W-1:0] r;
    logic                 zero;
    logic [EX_REG_AW-1:0] rd;
    logic                 wreg;
    logic                 mem_we;
    logic                 mem_re;
    logic [EX_DATA_W-1:0] pc;
    logic [EX_DATA_W-1:0] store_data;
  } ex_entry_t;

  function automatic logic is_add_sub(input logic [3:0] aluc);
    return (aluc == ALUC_ADD) || (aluc == ALUC_SUB);
  endfunction

endpackage

// File: rtl/ex_skid_buf.sv
// rtl/ex_skid_buf.sv - generic 2-entry valid/ready skid buffer with flush
// Main entry drives the output; skid catches the one beat accepted while main stalls.
module ex_skid_buf
  import ex_pkg::*;
#(
  parameter type T = ex_entry_t
) (
  input  logic clk,
  input  logic rst,
  input  logic flush,
  input  logic in_valid,
  output logic in_ready,
  input  T     in_data,
  output logic out_valid,
  input  logic out_ready,
  output T     out_data
);

  T     main_q, main_d;
  T     skid_q, skid_d;
  logic main_vld_q, main_vld_d;
  logic skid_vld_q, skid_vld_d;
  logic accept;
  logic pop;

  assign in_ready  = !skid_vld_q && !rst;
  assign out_valid = main_vld_q;
  assign out_data  = main_q;
  assign accept    = in_valid && in_ready;
  assign pop       = main_vld_q && out_ready;

  always_comb begin
    main_d     = main_q;
    skid_d     = skid_q;
    main_vld_d = main_vld_q;
    skid_vld_d = skid_vld_q;
    if (flush) begin
      main_vld_d = 1'b0;
      skid_vld_d = 1'b0;
    end else if (pop && skid_vld_q) begin
      main_d     = skid_q;
      skid_vld_d = 1'b0;
    end else if (pop || !main_vld_q) begin
      main_vld_d = accept;
      if (accept) main_d = in_data;
    end else if (accept) begin
      skid_d     = in_data;
      skid_vld_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      main_q     <= '0;
      skid_q     <= '0;
      main_vld_q <= 1'b0;
      skid_vld_q <= 1'b0;
    end else begin
      main_q     <= main_d;
      skid_q     <= skid_d;
      main_vld_q <= main_vld_d;
      skid_vld_q <= skid_vld_d;
    end
  end

endmodule

// File: rtl/ex_mem_stage.sv
// rtl/ex_mem_stage.sv - EX->MEM pipeline stage with skid buffer and overflow trap
// Trap detection is built only when ALU_OVF_TRAP_EN is defined.
module ex_mem_stage
  import ex_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] alu_r,
  input  logic              alu_zero,
  input  logic              alu_overflow,
  input  logic [3:0]        aluc,
  input  logic [REG_AW-1:0] rd,
  input  logic              wreg,
  input  logic              mem_we,
  input  logic              mem_re,
  input  logic [DATA_W-1:0] pc,
  input  logic [DATA_W-1:0] store_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_r,
  output logic              out_zero,
  output logic [REG_AW-1:0] out_rd,
  output logic              out_wreg,
  output logic              out_mem_we,
  output logic              out_mem_re,
  output logic [DATA_W-1:0] out_pc,
  output logic [DATA_W-1:0] out_store_data,
  output logic              exc_valid,
  output logic [DATA_W-1:0] exc_pc
);

  ex_entry_t in_entry;
  ex_entry_t head;
  logic      trap;

`ifdef ALU_OVF_TRAP_EN
  logic              exc_valid_q, exc_valid_d;
  logic [DATA_W-1:0] exc_pc_q, exc_pc_d;

  // The trap is raised on accept, independent of any flush in the same cycle.
  assign trap = in_valid && in_ready && alu_overflow && is_add_sub(aluc);

  always_comb begin
    exc_valid_d = trap;
    exc_pc_d    = trap ? pc : exc_pc_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      exc_valid_q <= 1'b0;
      exc_pc_q    <= '0;
    end else begin
      exc_valid_q <= exc_valid_d;
      exc_pc_q    <= exc_pc_d;
    end
  end

  assign exc_valid = exc_valid_q;
  assign exc_pc    = exc_pc_q;
`else
  logic unused_trap_inputs;
  assign unused_trap_inputs = ^{alu_overflow, aluc};
  assign trap      = 1'b0;
  assign exc_valid = 1'b0;
  assign exc_pc    = '0;
`endif

  always_comb begin
    in_entry.r          = alu_r;
    in_entry.zero       = alu_zero;
    in_entry.rd         = rd;
    in_entry.wreg       = wreg && !trap;
    in_entry.mem_we     = mem_we && !trap;
    in_entry.mem_re     = mem_re && !trap;
    in_entry.pc         = pc;
    in_entry.store_data = store_data;
  end

  ex_skid_buf #(.T(ex_entry_t)) u_skid (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_entry),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (head)
  );

  assign out_r          = head.r;
  assign out_zero       = head.zero;
  assign out_rd         = head.rd;
  assign out_wreg       = head.wreg;
  assign out_mem_we     = head.mem_we;
  assign out_mem_re     = head.mem_re;
  assign out_pc         = head.pc;
  assign out_store_data = head.store_data;

endmodule

// File: tb/tb_ex_mem_stage.sv
// tb/tb_ex_mem_stage.sv - self-checking bench for ex_mem_stage (honours ALU_OVF_TRAP_EN)
module tb_ex_mem_stage;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] alu_r;
  logic        alu_zero;
  logic        alu_overflow;
  logic [3:0]  aluc;
  logic [4:0]  rd;
  logic        wreg;
  logic        mem_we;
  logic        mem_re;
  logic [31:0] pc;
  logic [31:0] store_data;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_r;
  logic        out_zero;
  logic [4:0]  out_rd;
  logic        out_wreg;
  logic        out_mem_we;
  logic        out_mem_re;
  logic [31:0] out_pc;
  logic [31:0] out_store_data;
  logic        exc_valid;
  logic [31:0] exc_pc;

  ex_mem_stage #(.DATA_W(32), .REG_AW(5)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .alu_r(alu_r), .alu_zero(alu_zero), .alu_overflow(alu_overflow), .aluc(aluc),
    .rd(rd), .wreg(wreg), .mem_we(mem_we), .mem_re(mem_re), .pc(pc),
    .store_data(store_data), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .out_r(out_r), .out_zero(out_zero), .out_rd(out_rd), .out_wreg(out_wreg),
    .out_mem_we(out_mem_we), .out_mem_re(out_mem_re), .out_pc(out_pc),
    .out_store_data(out_store_data), .exc_valid(exc_valid), .exc_pc(exc_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fails  = 0;

  // Model: the stage behaves as a 2-deep FIFO that accepts only while it holds < 2 entries.
  logic [104:0] model_q[$];
  logic         exp_exc_valid = 1'b0;
  logic [31:0]  exp_exc_pc    = 32'h0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic traps(input logic [3:0] op, input logic ovf);
`ifdef ALU_OVF_TRAP_EN
    return ovf && (op == 4'd2 || op == 4'd3);
`else
    return 1'b0;
`endif
  endfunction

  // Inputs are set at the negedge before calling; one call covers one clock cycle.
  task automatic tick();
    logic         exp_rdy, acc, pop, tr;
    logic [104:0] e;
    logic [104:0] obs;
    exp_rdy = !rst && (model_q.size() < 2);
    #1;
    chk("in_ready", 128'(in_ready), 128'(exp_rdy));
    acc = in_valid && exp_rdy;
    pop = (model_q.size() > 0) && out_ready;
    tr  = acc && traps(aluc, alu_overflow);
    e   = {alu_r, alu_zero, rd, wreg && !tr, mem_we && !tr, mem_re && !tr, pc, store_data};
    @(posedge clk);
    #1;
    if (rst) begin
      model_q.delete();
      exp_exc_valid = 1'b0;
      exp_exc_pc    = 32'h0;
      obs = {out_r, out_zero, out_rd, out_wreg, out_mem_we, out_mem_re, out_pc, out_store_data};
      chk("rst_fields", 128'(obs), 128'(0));
    end else begin
      exp_exc_valid = tr;
      if (tr) exp_exc_pc = pc;
      if (flush) model_q.delete();
      else begin
        if (pop) void'(model_q.pop_front());
        if (acc) model_q.push_back(e);
      end
    end
    chk("out_valid", 128'(out_valid), 128'(model_q.size() > 0));
    if (model_q.size() > 0) begin
      obs = {out_r, out_zero, out_rd, out_wreg, out_mem_we, out_mem_re, out_pc, out_store_data};
      chk("head", 128'(obs), 128'(model_q[0]));
    end
    chk("exc_valid", 128'(exc_valid), 128'(exp_exc_valid));
    chk("exc_pc", 128'(exc_pc), 128'(exp_exc_pc));
    @(negedge clk);
  endtask

  task automatic set_in(input logic v, input logic [31:0] r, input logic [3:0] op,
                        input logic ovf, input logic [31:0] p);
    in_valid     = v;
    alu_r        = r;
    aluc         = op;
    alu_overflow = ovf;
    pc           = p;
    alu_zero     = (r == 32'h0);
    rd           = r[4:0] ^ 5'h11;
    wreg         = 1'b1;
    mem_we       = r[0];
    mem_re       = r[1];
    store_data   = ~r;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; out_ready = 1'b1;
    set_in(1'b0, 32'h0, 4'h0, 1'b0, 32'h0);
    @(negedge clk);
    tick();
    tick();
    rst = 1'b0;

    // Back-to-back flow
    for (int i = 1; i <= 4; i++) begin
      set_in(1'b1, 32'(i), 4'h0, 1'b0, 32'h100 + 32'(i));
      tick();
      chk("b2b_r", 128'(out_r), 128'(i));
    end
    in_valid = 1'b0;
    tick();

    // Backpressure
    out_ready = 1'b0;
    set_in(1'b1, 32'hA, 4'h0, 1'b0, 32'h200); tick();
    set_in(1'b1, 32'hB, 4'h0, 1'b0, 32'h204); tick();
    in_valid = 1'b0;
    tick();
    chk("bp_hold_r", 128'(out_r), 128'(32'hA));
    chk("bp_in_ready", 128'(in_ready), 128'(0));
    out_ready = 1'b1;
    tick();
    chk("bp_second_r", 128'(out_r), 128'(32'hB));
    tick();

    // Overflow trap vector, then the same vector with a non-add opcode
    set_in(1'b1, 32'h7FFF_FFFF, 4'b0010, 1'b1, 32'h0040_0010); tick();
`ifdef ALU_OVF_TRAP_EN
    chk("trap_wreg", 128'(out_wreg), 128'(0));
    chk("trap_exc", 128'(exc_valid), 128'(1));
    chk("trap_exc_pc", 128'(exc_pc), 128'(32'h0040_0010));
`else
    chk("notrap_wreg", 128'(out_wreg), 128'(1));
    chk("notrap_exc", 128'(exc_valid), 128'(0));
`endif
    set_in(1'b1, 32'h7FFF_FFFF, 4'b0000, 1'b1, 32'h0040_0014); tick();
    chk("and_wreg", 128'(out_wreg), 128'(1));
    chk("and_exc", 128'(exc_valid), 128'(0));
    in_valid = 1'b0;
    tick();

    // Flush with both entries full plus a new input
    out_ready = 1'b0;
    set_in(1'b1, 32'h11, 4'h0, 1'b0, 32'h300); tick();
    set_in(1'b1, 32'h22, 4'h0, 1'b0, 32'h304); tick();
    set_in(1'b1, 32'h33, 4'h0, 1'b0, 32'h308); flush = 1'b1; tick();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    chk("flush_valid", 128'(out_valid), 128'(0));
    tick(); tick();

    // Reset mid-backpressure
    out_ready = 1'b0;
    set_in(1'b1, 32'h44, 4'h0, 1'b0, 32'h400); tick();
    set_in(1'b1, 32'h55, 4'h0, 1'b0, 32'h404); tick();
    rst = 1'b1; tick();
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    tick();

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      logic [3:0] op;
      case ($urandom_range(0, 3))
        0: op = 4'b0010;
        1: op = 4'b0011;
        default: op = 4'($urandom);
      endcase
      set_in(1'($urandom_range(0, 3) != 0), $urandom, op, 1'($urandom), $urandom);
      wreg      = 1'($urandom);
      out_ready = 1'($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 24) == 0);
      rst       = ($urandom_range(0, 60) == 0);
      tick();
    end
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    tick(); tick(); tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
